// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pkg
// Description : Shared ALU-control, forward-select and bubble encodings for
//               the MIPS ID/EX operand stage.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

  localparam logic [1:0] ALU_AND = 2'b00;
  localparam logic [1:0] ALU_OR  = 2'b01;
  localparam logic [1:0] ALU_ADD = 2'b10;
  localparam logic [1:0] ALU_SUB = 2'b11;

  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  // A bubble is a valid-low slot whose ALU still sees a harmless ADD
  localparam logic       BUBBLE_VALID    = 1'b0;
  localparam logic [1:0] BUBBLE_ALU_CTRL = ALU_ADD;

endpackage
`default_nettype wire

// File: rtl/fwd_mux.sv
`default_nettype none
// ============================================================================
// Module      : fwd_mux
// Description : Per-source RAW bypass select; EX/MEM beats MEM/WB, and
//               register 0 is never forwarded.
// Revision    : 1.0 - initial release
// ============================================================================
module fwd_mux
  import mips_pkg::*;
#(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic [RW-1:0] src,
  input  logic [DW-1:0] reg_data,
  input  logic          exmem_reg_write,
  input  logic [RW-1:0] exmem_rd,
  input  logic [DW-1:0] exmem_result,
  input  logic          memwb_reg_write,
  input  logic [RW-1:0] memwb_rd,
  input  logic [DW-1:0] memwb_result,
  output logic [DW-1:0] fwd_data,
  output logic [1:0]    fwd_sel
);

  always_comb begin
    fwd_sel  = FWD_REG;
    fwd_data = reg_data;
    if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == src)) begin
      fwd_sel  = FWD_EXMEM;
      fwd_data = exmem_result;
    end else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == src)) begin
      fwd_sel  = FWD_MEMWB;
      fwd_data = memwb_result;
    end
  end

endmodule
`default_nettype wire

// File: rtl/id_ex_operand_stage.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_operand_stage
// Description : ID/EX pipeline register with operand forwarding and load-use
//               stall detection feeding the ALU.
// Revision    : 1.0 - initial release
// ============================================================================
module id_ex_operand_stage
  import mips_pkg::*;
#(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          id_valid,
  input  logic [DW-1:0] id_rs_data,
  input  logic [DW-1:0] id_rt_data,
  input  logic [15:0]   id_imm,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic [RW-1:0] id_rd,
  input  logic [1:0]    id_alu_ctrl,
  input  logic          id_alu_src,
  input  logic          id_reg_dst,
  input  logic          id_reg_write,
  input  logic          id_mem_read,
  input  logic          id_mem_write,
  input  logic          hold,
  input  logic          flush,
  input  logic          exmem_reg_write,
  input  logic [RW-1:0] exmem_rd,
  input  logic [DW-1:0] exmem_result,
  input  logic          memwb_reg_write,
  input  logic [RW-1:0] memwb_rd,
  input  logic [DW-1:0] memwb_result,
  output logic [DW-1:0] alu_op1,
  output logic [DW-1:0] alu_op2,
  output logic [1:0]    alu_ctrl,
  output logic          ex_valid,
  output logic [RW-1:0] ex_dest,
  output logic          ex_reg_write,
  output logic          ex_mem_read,
  output logic          ex_mem_write,
  output logic [DW-1:0] ex_store_data,
  output logic          load_use_stall
);

  logic          valid_q, valid_d;
  logic [RW-1:0] rs_q, rs_d, rt_q, rt_d, dest_q, dest_d;
  logic [DW-1:0] rs_data_q, rs_data_d, rt_data_q, rt_data_d, imm_q, imm_d;
  logic [1:0]    alu_ctrl_q, alu_ctrl_d;
  logic          alu_src_q, alu_src_d;
  logic          reg_write_q, reg_write_d;
  logic          mem_read_q, mem_read_d;
  logic          mem_write_q, mem_write_d;

  logic          stall;
  logic [DW-1:0] rs_fwd, rt_fwd;
  logic [1:0]    rs_sel, rt_sel;
  logic [3:0]    fwd_sel_unused;

  // An immediate-form consumer only reads rt when it is a store
  assign stall = !flush && valid_q && mem_read_q && (dest_q != '0) && id_valid &&
                 ((dest_q == id_rs) ||
                  ((dest_q == id_rt) && (!id_alu_src || id_mem_write)));

  always_comb begin
    valid_d     = valid_q;
    rs_d        = rs_q;
    rt_d        = rt_q;
    dest_d      = dest_q;
    rs_data_d   = rs_data_q;
    rt_data_d   = rt_data_q;
    imm_d       = imm_q;
    alu_ctrl_d  = alu_ctrl_q;
    alu_src_d   = alu_src_q;
    reg_write_d = reg_write_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    if (flush || (!hold && stall)) begin
      valid_d     = BUBBLE_VALID;
      rs_d        = '0;
      rt_d        = '0;
      dest_d      = '0;
      rs_data_d   = '0;
      rt_data_d   = '0;
      imm_d       = '0;
      alu_ctrl_d  = BUBBLE_ALU_CTRL;
      alu_src_d   = 1'b0;
      reg_write_d = 1'b0;
      mem_read_d  = 1'b0;
      mem_write_d = 1'b0;
    end else if (!hold) begin
      valid_d     = id_valid;
      rs_d        = id_rs;
      rt_d        = id_rt;
      dest_d      = id_reg_dst ? id_rd : id_rt;
      rs_data_d   = id_rs_data;
      rt_data_d   = id_rt_data;
      imm_d       = {{(DW-16){id_imm[15]}}, id_imm};
      alu_ctrl_d  = id_alu_ctrl;
      alu_src_d   = id_alu_src;
      reg_write_d = id_reg_write & id_valid;
      mem_read_d  = id_mem_read  & id_valid;
      mem_write_d = id_mem_write & id_valid;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= BUBBLE_VALID;
      rs_q        <= '0;
      rt_q        <= '0;
      dest_q      <= '0;
      rs_data_q   <= '0;
      rt_data_q   <= '0;
      imm_q       <= '0;
      alu_ctrl_q  <= BUBBLE_ALU_CTRL;
      alu_src_q   <= 1'b0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      rs_q        <= rs_d;
      rt_q        <= rt_d;
      dest_q      <= dest_d;
      rs_data_q   <= rs_data_d;
      rt_data_q   <= rt_data_d;
      imm_q       <= imm_d;
      alu_ctrl_q  <= alu_ctrl_d;
      alu_src_q   <= alu_src_d;
      reg_write_q <= reg_write_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
    end
  end

  fwd_mux #(.DW(DW), .RW(RW)) u_fwd_rs (
    .src             (rs_q),
    .reg_data        (rs_data_q),
    .exmem_reg_write (exmem_reg_write),
    .exmem_rd        (exmem_rd),
    .exmem_result    (exmem_result),
    .memwb_reg_write (memwb_reg_write),
    .memwb_rd        (memwb_rd),
    .memwb_result    (memwb_result),
    .fwd_data        (rs_fwd),
    .fwd_sel         (rs_sel)
  );

  fwd_mux #(.DW(DW), .RW(RW)) u_fwd_rt (
    .src             (rt_q),
    .reg_data        (rt_data_q),
    .exmem_reg_write (exmem_reg_write),
    .exmem_rd        (exmem_rd),
    .exmem_result    (exmem_result),
    .memwb_reg_write (memwb_reg_write),
    .memwb_rd        (memwb_rd),
    .memwb_result    (memwb_result),
    .fwd_data        (rt_fwd),
    .fwd_sel         (rt_sel)
  );

  // Select codes are kept for debug visibility only
  assign fwd_sel_unused = {rs_sel, rt_sel};

  assign alu_op1        = rs_fwd;
  assign alu_op2        = alu_src_q ? imm_q : rt_fwd;
  assign ex_store_data  = rt_fwd;
  assign alu_ctrl       = alu_ctrl_q;
  assign ex_valid       = valid_q;
  assign ex_dest        = dest_q;
  assign ex_reg_write   = reg_write_q;
  assign ex_mem_read    = mem_read_q;
  assign ex_mem_write   = mem_write_q;
  assign load_use_stall = stall;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_operand_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_ex_operand_stage
// Description : Self-checking bench for id_ex_operand_stage with directed
//               scenarios and a randomized run against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_ex_operand_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [31:0] id_rs_data, id_rt_data;
  logic [15:0] id_imm;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [1:0]  id_alu_ctrl;
  logic        id_alu_src, id_reg_dst, id_reg_write, id_mem_read, id_mem_write;
  logic        hold, flush;
  logic        exmem_reg_write, memwb_reg_write;
  logic [4:0]  exmem_rd, memwb_rd;
  logic [31:0] exmem_result, memwb_result;
  logic [31:0] alu_op1, alu_op2, ex_store_data;
  logic [1:0]  alu_ctrl;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, load_use_stall;
  logic [4:0]  ex_dest;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  id_ex_operand_stage #(.DW(32), .RW(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .id_imm(id_imm), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_alu_ctrl(id_alu_ctrl), .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .hold(hold), .flush(flush),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_ctrl(alu_ctrl),
    .ex_valid(ex_valid), .ex_dest(ex_dest),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_store_data(ex_store_data), .load_use_stall(load_use_stall)
  );

  // Reference model: the instruction currently occupying the EX slot
  typedef struct {
    logic        v;
    logic [4:0]  rs, rt, dest;
    logic [31:0] rsd, rtd, imm;
    logic [1:0]  ctrl;
    logic        src, rw, mr, mw;
  } stage_t;

  stage_t m;

  function automatic stage_t bubble();
    stage_t b;
    b.v = 0; b.rs = 0; b.rt = 0; b.dest = 0;
    b.rsd = 0; b.rtd = 0; b.imm = 0;
    b.ctrl = 2'b10; b.src = 0; b.rw = 0; b.mr = 0; b.mw = 0;
    return b;
  endfunction

  function automatic logic [31:0] fwd(input logic [4:0] idx, input logic [31:0] d);
    if (exmem_reg_write && exmem_rd != 0 && exmem_rd == idx) return exmem_result;
    if (memwb_reg_write && memwb_rd != 0 && memwb_rd == idx) return memwb_result;
    return d;
  endfunction

  function automatic logic exp_stall();
    if (flush) return 1'b0;
    return m.v && m.mr && (m.dest != 0) && id_valid &&
           ((m.dest == id_rs) || ((m.dest == id_rt) && (!id_alu_src || id_mem_write)));
  endfunction

  function automatic stage_t next_model();
    stage_t n;
    if (flush) return bubble();
    if (hold) return m;
    if (exp_stall()) return bubble();
    n.v    = id_valid;
    n.rs   = id_rs;
    n.rt   = id_rt;
    n.dest = id_reg_dst ? id_rd : id_rt;
    n.rsd  = id_rs_data;
    n.rtd  = id_rt_data;
    n.imm  = 32'($signed(id_imm));
    n.ctrl = id_alu_ctrl;
    n.src  = id_alu_src;
    n.rw   = id_reg_write && id_valid;
    n.mr   = id_mem_read && id_valid;
    n.mw   = id_mem_write && id_valid;
    return n;
  endfunction

  task automatic tick();
    stage_t nx;
    nx = next_model();
    @(posedge clk);
    m = nx;
    #1;
  endtask

  task automatic clear_inputs();
    id_valid = 0; id_rs_data = 0; id_rt_data = 0; id_imm = 0;
    id_rs = 0; id_rt = 0; id_rd = 0; id_alu_ctrl = 0;
    id_alu_src = 0; id_reg_dst = 0; id_reg_write = 0; id_mem_read = 0; id_mem_write = 0;
    hold = 0; flush = 0;
    exmem_reg_write = 0; exmem_rd = 0; exmem_result = 0;
    memwb_reg_write = 0; memwb_rd = 0; memwb_result = 0;
  endtask

  task automatic load_lw(input logic [4:0] dst);
    clear_inputs();
    id_valid = 1; id_mem_read = 1; id_reg_write = 1; id_alu_src = 1;
    id_rs = 5'd1; id_rt = dst; id_reg_dst = 0; id_alu_ctrl = 2'b10;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 0;
    clear_inputs();
    m = bubble();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    total_cnt++; if (ex_valid !== 1'b0) $display("FAIL reset_valid: got %0h want 0", ex_valid); else pass_cnt++;
    total_cnt++; if (alu_ctrl !== 2'b10) $display("FAIL reset_alu_ctrl: got %0h want 2", alu_ctrl); else pass_cnt++;
    id_valid = 1; id_rs = 5'd3; id_rs_data = 32'h1234; id_rt = 5'd4; id_rt_data = 32'h5678;
    id_alu_ctrl = 2'b01; id_reg_write = 1;
    tick();
    #2 rst_n = 0;
    #1;
    m = bubble();
    total_cnt++; if (ex_valid !== 1'b0) $display("FAIL async_reset_valid: got %0h want 0", ex_valid); else pass_cnt++;
    total_cnt++; if (alu_ctrl !== 2'b10) $display("FAIL async_reset_ctrl: got %0h want 2", alu_ctrl); else pass_cnt++;
    total_cnt++; if (alu_op1 !== 32'h0) $display("FAIL async_reset_op1: got %0h want 0", alu_op1); else pass_cnt++;
    total_cnt++; if (alu_op2 !== 32'h0) $display("FAIL async_reset_op2: got %0h want 0", alu_op2); else pass_cnt++;
    total_cnt++; if (ex_reg_write !== 1'b0) $display("FAIL async_reset_rw: got %0h want 0", ex_reg_write); else pass_cnt++;
    @(negedge clk);
    rst_n = 1;
    clear_inputs();
  endtask

  task automatic test_basic();
    clear_inputs();
    id_valid = 1; id_rs = 5'd1; id_rs_data = 32'd5; id_rt = 5'd2; id_rt_data = 32'd3;
    id_alu_ctrl = 2'b11; id_reg_dst = 1; id_rd = 5'd4; id_reg_write = 1;
    tick();
    total_cnt++; if (alu_op1 !== 32'd5) $display("FAIL basic_op1: got %0h want 5", alu_op1); else pass_cnt++;
    total_cnt++; if (alu_op2 !== 32'd3) $display("FAIL basic_op2: got %0h want 3", alu_op2); else pass_cnt++;
    total_cnt++; if (alu_ctrl !== 2'b11) $display("FAIL basic_ctrl: got %0h want 3", alu_ctrl); else pass_cnt++;
    total_cnt++; if (ex_valid !== 1'b1) $display("FAIL basic_valid: got %0h want 1", ex_valid); else pass_cnt++;
    total_cnt++; if (ex_dest !== 5'd4) $display("FAIL basic_dest: got %0h want 4", ex_dest); else pass_cnt++;
    total_cnt++; if (ex_reg_write !== 1'b1) $display("FAIL basic_rw: got %0h want 1", ex_reg_write); else pass_cnt++;
    id_valid = 0; id_mem_write = 1; id_reg_dst = 0; id_rt = 5'd6;
    tick();
    total_cnt++; if (ex_mem_write !== 1'b0) $display("FAIL invalid_gates_ctrl: got %0h want 0", ex_mem_write); else pass_cnt++;
    total_cnt++; if (ex_dest !== 5'd6) $display("FAIL dest_rt: got %0h want 6", ex_dest); else pass_cnt++;
  endtask

  task automatic test_immediate();
    clear_inputs();
    id_valid = 1; id_imm = 16'hFFFC; id_alu_src = 1; id_rt = 5'd2; id_rt_data = 32'd3;
    id_alu_ctrl = 2'b10;
    tick();
    total_cnt++; if (alu_op2 !== 32'hFFFFFFFC) $display("FAIL imm_neg: got %0h want fffffffc", alu_op2); else pass_cnt++;
    total_cnt++; if (ex_store_data !== 32'd3) $display("FAIL imm_store_data: got %0h want 3", ex_store_data); else pass_cnt++;
    id_imm = 16'h7FF0;
    tick();
    total_cnt++; if (alu_op2 !== 32'h00007FF0) $display("FAIL imm_pos: got %0h want 7ff0", alu_op2); else pass_cnt++;
  endtask

  task automatic test_forward();
    clear_inputs();
    id_valid = 1; id_rs = 5'd8; id_rs_data = 32'h11; id_rt = 5'd8; id_rt_data = 32'h33;
    tick();
    exmem_reg_write = 1; exmem_rd = 5'd8; exmem_result = 32'hAA;
    memwb_reg_write = 1; memwb_rd = 5'd8; memwb_result = 32'hBB;
    #1;
    total_cnt++; if (alu_op1 !== 32'hAA) $display("FAIL fwd_exmem_wins: got %0h want aa", alu_op1); else pass_cnt++;
    total_cnt++; if (ex_store_data !== 32'hAA) $display("FAIL fwd_store_exmem: got %0h want aa", ex_store_data); else pass_cnt++;
    exmem_reg_write = 0;
    #1;
    total_cnt++; if (alu_op1 !== 32'hBB) $display("FAIL fwd_memwb: got %0h want bb", alu_op1); else pass_cnt++;
    memwb_reg_write = 0;
    #1;
    total_cnt++; if (alu_op1 !== 32'h11) $display("FAIL fwd_none: got %0h want 11", alu_op1); else pass_cnt++;
    id_rs = 5'd0; id_rs_data = 32'h22;
    tick();
    exmem_reg_write = 1; exmem_rd = 5'd0; exmem_result = 32'hAA;
    memwb_reg_write = 1; memwb_rd = 5'd0; memwb_result = 32'hBB;
    #1;
    total_cnt++; if (alu_op1 !== 32'h22) $display("FAIL fwd_reg0: got %0h want 22", alu_op1); else pass_cnt++;
    clear_inputs();
  endtask

  task automatic test_load_use();
    load_lw(5'd9);
    clear_inputs();
    id_valid = 1; id_rs = 5'd9; id_rt = 5'd2; id_reg_write = 1; id_reg_dst = 1; id_rd = 5'd3;
    #1;
    total_cnt++; if (load_use_stall !== 1'b1) $display("FAIL lu_stall_rs: got %0h want 1", load_use_stall); else pass_cnt++;
    tick();
    total_cnt++; if (ex_valid !== 1'b0) $display("FAIL lu_bubble: got %0h want 0", ex_valid); else pass_cnt++;
    total_cnt++; if (load_use_stall !== 1'b0) $display("FAIL lu_drop: got %0h want 0", load_use_stall); else pass_cnt++;
    load_lw(5'd9);
    clear_inputs();
    id_valid = 1; id_rs = 5'd9; flush = 1;
    #1;
    total_cnt++; if (load_use_stall !== 1'b0) $display("FAIL lu_flush_masks: got %0h want 0", load_use_stall); else pass_cnt++;
    tick();
    total_cnt++; if (ex_valid !== 1'b0) $display("FAIL lu_flush_bubble: got %0h want 0", ex_valid); else pass_cnt++;
    load_lw(5'd9);
    clear_inputs();
    id_valid = 1; id_rs = 5'd1; id_rt = 5'd9; id_alu_src = 1;
    #1;
    total_cnt++; if (load_use_stall !== 1'b0) $display("FAIL lu_imm_rt_nostall: got %0h want 0", load_use_stall); else pass_cnt++;
    id_mem_write = 1;
    #1;
    total_cnt++; if (load_use_stall !== 1'b1) $display("FAIL lu_store_rt: got %0h want 1", load_use_stall); else pass_cnt++;
    load_lw(5'd0);
    clear_inputs();
    id_valid = 1; id_rs = 5'd0;
    #1;
    total_cnt++; if (load_use_stall !== 1'b0) $display("FAIL lu_dest0: got %0h want 0", load_use_stall); else pass_cnt++;
    clear_inputs();
  endtask

  task automatic test_hold();
    clear_inputs();
    id_valid = 1; id_rs = 5'd5; id_rs_data = 32'h50; id_rt = 5'd6; id_rt_data = 32'h60;
    id_alu_ctrl = 2'b11; id_reg_dst = 1; id_rd = 5'd7; id_reg_write = 1;
    tick();
    hold = 1;
    for (int i = 0; i < 3; i++) begin
      id_valid = 1'($urandom); id_rs_data = $urandom; id_rt_data = $urandom;
      id_rs = 5'($urandom); id_rt = 5'($urandom); id_rd = 5'($urandom);
      id_alu_ctrl = 2'($urandom); id_reg_dst = 1'($urandom);
      tick();
      total_cnt++; if (ex_valid !== 1'b1) $display("FAIL hold_valid: got %0h want 1", ex_valid); else pass_cnt++;
      total_cnt++; if (alu_op1 !== 32'h50) $display("FAIL hold_op1: got %0h want 50", alu_op1); else pass_cnt++;
      total_cnt++; if (alu_op2 !== 32'h60) $display("FAIL hold_op2: got %0h want 60", alu_op2); else pass_cnt++;
      total_cnt++; if (alu_ctrl !== 2'b11) $display("FAIL hold_ctrl: got %0h want 3", alu_ctrl); else pass_cnt++;
      total_cnt++; if (ex_dest !== 5'd7) $display("FAIL hold_dest: got %0h want 7", ex_dest); else pass_cnt++;
      if (i == 1) begin
        exmem_reg_write = 1; exmem_rd = 5'd5; exmem_result = 32'hCAFE;
        #1;
        total_cnt++; if (alu_op1 !== 32'hCAFE) $display("FAIL hold_fwd_tracks: got %0h want cafe", alu_op1); else pass_cnt++;
        exmem_reg_write = 0;
      end
    end
    flush = 1;
    tick();
    total_cnt++; if (ex_valid !== 1'b0) $display("FAIL hold_flush_valid: got %0h want 0", ex_valid); else pass_cnt++;
    total_cnt++; if (alu_ctrl !== 2'b10) $display("FAIL hold_flush_ctrl: got %0h want 2", alu_ctrl); else pass_cnt++;
    total_cnt++; if (ex_dest !== 5'd0) $display("FAIL hold_flush_dest: got %0h want 0", ex_dest); else pass_cnt++;
    clear_inputs();
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      id_valid = ($urandom_range(0, 3) != 0);
      id_rs_data = $urandom; id_rt_data = $urandom; id_imm = 16'($urandom);
      id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
      id_rd = 5'($urandom_range(0, 3));
      id_alu_ctrl = 2'($urandom); id_alu_src = 1'($urandom); id_reg_dst = 1'($urandom);
      id_reg_write = 1'($urandom); id_mem_read = ($urandom_range(0, 2) == 0);
      id_mem_write = ($urandom_range(0, 3) == 0);
      hold = ($urandom_range(0, 7) == 0); flush = ($urandom_range(0, 7) == 0);
      exmem_reg_write = 1'($urandom); exmem_rd = 5'($urandom_range(0, 3)); exmem_result = $urandom;
      memwb_reg_write = 1'($urandom); memwb_rd = 5'($urandom_range(0, 3)); memwb_result = $urandom;
      #1;
      total_cnt++; if (load_use_stall !== exp_stall()) $display("FAIL rnd_stall[%0d]: got %0h want %0h", i, load_use_stall, exp_stall()); else pass_cnt++;
      total_cnt++; if (alu_op1 !== fwd(m.rs, m.rsd)) $display("FAIL rnd_op1[%0d]: got %0h want %0h", i, alu_op1, fwd(m.rs, m.rsd)); else pass_cnt++;
      total_cnt++; if (alu_op2 !== (m.src ? m.imm : fwd(m.rt, m.rtd))) $display("FAIL rnd_op2[%0d]: got %0h want %0h", i, alu_op2, (m.src ? m.imm : fwd(m.rt, m.rtd))); else pass_cnt++;
      total_cnt++; if (ex_store_data !== fwd(m.rt, m.rtd)) $display("FAIL rnd_store[%0d]: got %0h want %0h", i, ex_store_data, fwd(m.rt, m.rtd)); else pass_cnt++;
      total_cnt++; if (alu_ctrl !== m.ctrl) $display("FAIL rnd_ctrl[%0d]: got %0h want %0h", i, alu_ctrl, m.ctrl); else pass_cnt++;
      total_cnt++; if (ex_valid !== m.v) $display("FAIL rnd_valid[%0d]: got %0h want %0h", i, ex_valid, m.v); else pass_cnt++;
      total_cnt++; if (ex_dest !== m.dest) $display("FAIL rnd_dest[%0d]: got %0h want %0h", i, ex_dest, m.dest); else pass_cnt++;
      total_cnt++; if ({ex_reg_write, ex_mem_read, ex_mem_write} !== {m.rw, m.mr, m.mw}) $display("FAIL rnd_ctrl_bits[%0d]: got %0b want %0b", i, {ex_reg_write, ex_mem_read, ex_mem_write}, {m.rw, m.mr, m.mw}); else pass_cnt++;
      tick();
    end
    clear_inputs();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_immediate();
    test_forward();
    test_load_use();
    test_hold();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
